// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the bus-based datapath.
// Sequences fetch (T0-T2) and execute steps for ld/st/add/sub/and/or/nop/halt,
// pacing memory accesses on Mem_ready.
module control_sequencer #(
    parameter int unsigned STATE_W = 5
) (
    input  logic               Clock,
    input  logic               Clear,
    input  logic               Run,
    input  logic [31:0]        IR,
    input  logic               Mem_ready,
    output logic               PCout,
    output logic               Zhighout,
    output logic               Zlowout,
    output logic               MDRout,
    output logic               BAout,
    output logic               Cout,
    output logic               Gra,
    output logic               Grb,
    output logic               Grc,
    output logic               Rin,
    output logic               Rout,
    output logic               MARin,
    output logic               Zin,
    output logic               PCin,
    output logic               MDRin,
    output logic               IRin,
    output logic               Yin,
    output logic               IncPC,
    output logic               Read,
    output logic               Write,
    output logic               ADD,
    output logic               SUB,
    output logic               AND,
    output logic               OR,
    output logic               Halted,
    output logic [STATE_W-1:0] Present_state
);

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpHalt = 5'b11011;

    typedef enum logic [STATE_W-1:0] {
        StReset, StT0, StT1, StT1w, StT2, StDec,
        StA3, StA4, StA5,
        StM3, StM4, StM5,
        StL6, StL7, StS6, StS7,
        StHalt
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] op_q, op_d;

    // Register fields are decoded by the datapath, not here.
    logic unused_ir_fields;
    assign unused_ir_fields = ^IR[26:0];

    // State and latched opcode; Clear overrides everything.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= StReset;
            op_q    <= 5'b00000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Opcode is captured in DEC so A4/M5 stay a function of registered state.
    always_comb begin
        op_d = (state_q == StDec) ? IR[31:27] : op_q;
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReset: state_d = Run ? StT0 : StReset;
            StT0:    state_d = StT1;
            StT1:    state_d = StT1w;
            StT1w:   state_d = Mem_ready ? StT2 : StT1w;
            StT2:    state_d = StDec;
            StDec: begin
                case (IR[31:27])
                    OpLd, OpSt:                 state_d = StM3;
                    OpAdd, OpSub, OpAnd, OpOr:  state_d = StA3;
                    OpHalt:                     state_d = StHalt;
                    default:                    state_d = StT0;
                endcase
            end
            StA3:    state_d = StA4;
            StA4:    state_d = StA5;
            StA5:    state_d = StT0;
            StM3:    state_d = StM4;
            StM4:    state_d = StM5;
            StM5:    state_d = (op_q == OpSt) ? StS6 : StL6;
            StL6:    state_d = Mem_ready ? StL7 : StL6;
            StL7:    state_d = StT0;
            StS6:    state_d = StS7;
            StS7:    state_d = Mem_ready ? StT0 : StS7;
            StHalt:  state_d = StHalt;
            default: state_d = StReset;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
        BAout = 1'b0; Cout = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        Rin = 1'b0; Rout = 1'b0; MARin = 1'b0; Zin = 1'b0; PCin = 1'b0;
        MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; IncPC = 1'b0; Read = 1'b0;
        Write = 1'b0; ADD = 1'b0; SUB = 1'b0; AND = 1'b0; OR = 1'b0;
        Halted = 1'b0;
        unique case (state_q)
            StT0:  begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            StT1:  begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            StT1w: begin Read = 1'b1; MDRin = 1'b1; end
            StT2:  begin MDRout = 1'b1; IRin = 1'b1; end
            StA3:  begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            StA4: begin
                Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                case (op_q)
                    OpAdd:   ADD = 1'b1;
                    OpSub:   SUB = 1'b1;
                    OpAnd:   AND = 1'b1;
                    OpOr:    OR  = 1'b1;
                    default: ;
                endcase
            end
            StA5:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            StM3:  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            StM4:  begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
            StM5:  begin Zlowout = 1'b1; MARin = 1'b1; end
            StL6:  begin Read = 1'b1; MDRin = 1'b1; end
            StL7:  begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            StS6:  begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            StS7:  Write = 1'b1;
            StHalt: Halted = 1'b1;
            default: ;
        endcase
    end

    assign Present_state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: each cycle's stimulus is
// paired with the control word the instruction's step list says must appear.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        Run = 1'b0;
    logic [31:0] IR = 32'h0;
    logic        Mem_ready = 1'b0;
    logic PCout, Zhighout, Zlowout, MDRout, BAout, Cout, Gra, Grb, Grc, Rin, Rout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, Write;
    logic ADD, SUB, AND, OR, Halted;
    logic [4:0] Present_state;

    control_sequencer #(.STATE_W(5)) dut (
        .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR), .Mem_ready(Mem_ready),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .BAout(BAout), .Cout(Cout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read), .Write(Write),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .Halted(Halted),
        .Present_state(Present_state)
    );

    always #5 Clock = ~Clock;

    // Control-word bit positions.
    localparam logic [24:0] B_PCOUT = 25'd1 << 24, B_ZHI = 25'd1 << 23, B_ZLO = 25'd1 << 22;
    localparam logic [24:0] B_MDROUT = 25'd1 << 21, B_BAOUT = 25'd1 << 20, B_COUT = 25'd1 << 19;
    localparam logic [24:0] B_GRA = 25'd1 << 18, B_GRB = 25'd1 << 17, B_GRC = 25'd1 << 16;
    localparam logic [24:0] B_RIN = 25'd1 << 15, B_ROUT = 25'd1 << 14, B_MARIN = 25'd1 << 13;
    localparam logic [24:0] B_ZIN = 25'd1 << 12, B_PCIN = 25'd1 << 11, B_MDRIN = 25'd1 << 10;
    localparam logic [24:0] B_IRIN = 25'd1 << 9, B_YIN = 25'd1 << 8, B_INCPC = 25'd1 << 7;
    localparam logic [24:0] B_READ = 25'd1 << 6, B_WRITE = 25'd1 << 5, B_ADD = 25'd1 << 4;
    localparam logic [24:0] B_SUB = 25'd1 << 3, B_AND = 25'd1 << 2, B_OR = 25'd1 << 1;
    localparam logic [24:0] B_HALTED = 25'd1;

    logic [24:0] obs;
    assign obs = {PCout, Zhighout, Zlowout, MDRout, BAout, Cout, Gra, Grb, Grc, Rin, Rout,
                  MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, Write,
                  ADD, SUB, AND, OR, Halted};

    typedef struct {
        logic        clear;
        logic        run;
        logic        mr;
        logic [31:0] ir;
        logic [24:0] exp;
    } ent_t;

    ent_t        stim_q[$];
    logic [24:0] exp_q[$];
    logic [31:0] cur_ir = 32'h0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_cycle = 0;

    task automatic chk(input string name, input logic [24:0] act, input logic [24:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s at step %0d: got %h, expected %h", name, n_cycle, act, expv);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add_full(input logic [24:0] e, input logic mr, input logic clr,
                            input logic run);
        ent_t t;
        t.clear = clr; t.run = run; t.mr = mr; t.ir = cur_ir; t.exp = e;
        stim_q.push_back(t);
    endtask

    // Outside RESET, Run is irrelevant, so it is randomized.
    task automatic add(input logic [24:0] e, input logic mr);
        add_full(e, mr, 1'b0, rb());
    endtask

    // A memory wait step: held for w low cycles of Mem_ready, then one ready cycle.
    task automatic add_wait(input logic [24:0] e, input int w);
        for (int i = 0; i < w; i++) add(e, 1'b0);
        add(e, 1'b1);
    endtask

    function automatic logic [24:0] alu_mask(input logic [4:0] op);
        case (op)
            5'd3:    return B_ADD;
            5'd4:    return B_SUB;
            5'd5:    return B_AND;
            5'd6:    return B_OR;
            default: return 25'd0;
        endcase
    endfunction

    // Expected step list for one instruction, starting from its T0.
    task automatic instr(input logic [31:0] ir, input int tw, input int mw, input bit clr_a4);
        logic [4:0] op;
        cur_ir = ir;
        op = ir[31:27];
        add(B_PCOUT | B_MARIN | B_INCPC | B_ZIN, rb());
        add(B_ZLO | B_PCIN | B_READ | B_MDRIN, rb());
        add_wait(B_READ | B_MDRIN, tw);
        add(B_MDROUT | B_IRIN, rb());
        add(25'd0, rb());
        if (op >= 5'd3 && op <= 5'd6) begin
            add(B_GRB | B_ROUT | B_YIN, rb());
            add_full(B_GRC | B_ROUT | B_ZIN | alu_mask(op), rb(), clr_a4, rb());
            if (clr_a4) begin
                add_full(25'd0, rb(), 1'b0, 1'b0);
                add_full(25'd0, rb(), 1'b0, 1'b1);
            end else begin
                add(B_ZLO | B_GRA | B_RIN, rb());
            end
        end else if (op == 5'd0 || op == 5'd2) begin
            add(B_GRB | B_BAOUT | B_YIN, rb());
            add(B_COUT | B_ADD | B_ZIN, rb());
            add(B_ZLO | B_MARIN, rb());
            if (op == 5'd0) begin
                add_wait(B_READ | B_MDRIN, mw);
                add(B_MDROUT | B_GRA | B_RIN, rb());
            end else begin
                add(B_GRA | B_ROUT | B_MDRIN, rb());
                add_wait(B_WRITE, mw);
            end
        end else if (op == 5'd27) begin
            for (int i = 0; i < 8; i++) add(B_HALTED, rb());
            add_full(B_HALTED, rb(), 1'b1, rb());
            add_full(25'd0, rb(), 1'b0, 1'b0);
            add_full(25'd0, rb(), 1'b0, 1'b1);
        end
    endtask

    // Monitor: pops one expected word per cycle and checks it plus invariants.
    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            logic [24:0] e;
            e = exp_q.pop_front();
            chk("control_word", obs, e);
            chk("single_bus_driver",
                {24'd0, ($countones({PCout, Zhighout, Zlowout, MDRout, BAout, Cout, Rout}) > 1)},
                25'd0);
            chk("read_write_excl", {24'd0, Read & Write}, 25'd0);
            chk("alu_onehot", {24'd0, ($countones({ADD, SUB, AND, OR}) > 1)}, 25'd0);
            n_cycle++;
        end
    end

    initial begin
        logic [4:0] op;
        int         k;
        // Reset: Clear for two cycles, idle with Run low, then start.
        add_full(25'd0, 1'b0, 1'b1, 1'b0);
        add_full(25'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) add_full(25'd0, rb(), 1'b0, 1'b0);
        add_full(25'd0, rb(), 1'b0, 1'b1);
        // Directed instructions.
        instr(32'h1A920000, 0, 0, 1'b0);
        instr(32'h22920000, 0, 0, 1'b0);
        instr(32'h2A920000, 0, 0, 1'b0);
        instr(32'h32920000, 0, 0, 1'b0);
        instr(32'h00920000, 0, 3, 1'b0);
        instr(32'h10920000, 0, 0, 1'b0);
        instr(32'hD0000000, 2, 0, 1'b0);
        instr(32'h1A920000, 0, 0, 1'b1);
        // Random instruction mix, including unassigned opcodes and memory waits.
        for (int n = 0; n < 40; n++) begin
            k = int'($urandom_range(0, 8));
            case (k)
                0: op = 5'd0;
                1: op = 5'd2;
                2: op = 5'd3;
                3: op = 5'd4;
                4: op = 5'd5;
                5: op = 5'd6;
                6: op = 5'd26;
                default: begin
                    op = 5'($urandom_range(0, 31));
                    while (op == 5'd0 || (op >= 5'd2 && op <= 5'd6) || op == 5'd27)
                        op = 5'($urandom_range(0, 31));
                end
            endcase
            instr({op, 27'($urandom)}, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
        end
        instr(32'hD8000000, 1, 0, 1'b0);

        // Drive: inputs applied just after each edge, expectation queued alongside.
        foreach (stim_q[i]) begin
            @(posedge Clock);
            #1;
            Clear     = stim_q[i].clear;
            Run       = stim_q[i].run;
            Mem_ready = stim_q[i].mr;
            IR        = stim_q[i].ir;
            exp_q.push_back(stim_q[i].exp);
        end
        repeat (3) @(posedge Clock);
        chk("scoreboard_drained", 25'(exp_q.size()), 25'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
